deserializador_buf: RTL and testbench
=====================================

DESERIALIZADOR_BUF -- requirements
Module: deserializador_buf

Interface
REQ-001 WIDTH, 8, word width in bits; legal range 2..32.
REQ-002 LSB_FIRST, 0, 0 = first received bit lands in data_out[WIDTH-1]; 1 = first received bit lands in data_out[0].
REQ-003 clk_100KHz  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  1  serial data bit, sampled when write_in=1.
REQ-006 write_in  input  1  a bit is offered on every rising edge where write_in=1.
REQ-007 ack_in  input  1  consumer acknowledge, four-phase.
REQ-008 data_out  output  WIDTH  assembled word, valid while data_ready=1, else 0.
REQ-009 data_ready  output  1  output word held for consumer.
REQ-010 status_out  output  1  1 = block cannot accept bits (shifter full and output occupied).
REQ-011 overrun_out  output  1  one-cycle pulse for each offered bit that is dropped.
REQ-012 count_out  output  $clog2(WIDTH+1)  number of bits currently in the shifter.

Function
REQ-013 The shifter FSM SHALL have states S_FILL and S_FULL; the output FSM SHALL have states O_IDLE, O_VALID and O_ACK.
REQ-014 In S_FILL with write_in=1, the bit SHALL be shifted in per LSB_FIRST, and count SHALL increment.
REQ-015 In S_FILL with write_in=0, the shifter and count SHALL hold.
REQ-016 When the WIDTH-th bit is captured with the output FSM in O_IDLE, the edge SHALL load data_out, set data_ready=1, enter O_VALID, and return the shifter to S_FILL with count=0 (latency: data_ready high the cycle after the last bit).
REQ-017 When the WIDTH-th bit is captured with the output FSM not in O_IDLE, the shifter SHALL enter S_FULL with count=WIDTH.
REQ-018 In S_FULL, status_out SHALL be 1.
REQ-019 In S_FULL, each write_in=1 SHALL leave the shifter unchanged and pulse overrun_out for exactly that cycle.
REQ-020 In S_FULL with the output FSM in O_IDLE, the next edge SHALL transfer the word to data_out, set data_ready=1, enter O_VALID, and enter S_FILL with count=0.
REQ-021 O_VALID with ack_in=1 SHALL go to O_ACK; data_ready and data_out SHALL hold.
REQ-022 O_ACK with ack_in=0 SHALL clear data_ready and data_out to 0 and go to O_IDLE.
REQ-023 O_ACK with ack_in=1 SHALL remain in O_ACK.
REQ-024 ack_in SHALL be ignored in O_IDLE.
REQ-025 A release edge (O_ACK to O_IDLE) coinciding with a word completion SHALL follow REQ-017; the word appears one edge later via REQ-020.
REQ-026 Count arithmetic SHALL never exceed WIDTH or wrap.

Reset
REQ-027 While reset=1, data_out, data_ready, status_out, overrun_out and count_out SHALL be 0, the shifter SHALL be cleared, and the FSMs SHALL be in S_FILL and O_IDLE.
REQ-028 Reset asserted mid-word or mid-handshake SHALL discard partial and pending words; the first bit after release SHALL start a new word.

Structure
REQ-029 Package deserializador_pkg SHALL hold the shift_state_t and out_state_t enums.
REQ-030 The shifter and counter SHALL be sub-module deser_shift_reg (parameters WIDTH, LSB_FIRST; ports load, clear, full, count, word); the FSMs SHALL live in the top module.

Verification (WIDTH=8 unless stated)
REQ-031 Bits 1,1,0,0,0,0,0,0 on consecutive cycles -> data_out=0xC0 and data_ready=1 one cycle after the 8th bit; with LSB_FIRST=1 -> data_out=0x03.
REQ-032 ack_in high 3 cycles then low -> data_ready stays 1 until the edge after ack_in falls, then data_ready=0 and data_out=0x00.
REQ-033 Word 0xA5 unacked, then 0x3C fully shifted -> status_out=1 and count_out=8; 3 further write_in pulses -> 3 overrun_out pulses; after the 0xA5 handshake release -> data_out=0x3C one edge later and status_out=0.
REQ-034 Reset pulsed after 5 bits -> all outputs 0 immediately; next 8 bits 0x5A -> data_out=0x5A.
REQ-035 write_in gapped (one bit every 3 cycles) for 0x81, with ack_in pulsed while idle -> data_out=0x81 and no spurious state change.
REQ-036 WIDTH=12, bits forming 0xABC MSB-first -> data_out=12'hABC and count_out reaches 12 only if output occupied.

Source files
------------

// File: rtl/deserializador_pkg.sv
// Shared FSM state types and the bit-insertion helper for the buffered deserializer.
package deserializador_pkg;

  typedef enum logic {
    S_FILL,
    S_FULL
  } shift_state_t;

  typedef enum logic [1:0] {
    O_IDLE,
    O_VALID,
    O_ACK
  } out_state_t;

  localparam int unsigned MAX_WIDTH = 32;

  // Insert one serial bit into a word of the given width; upper bits of w must be zero.
  function automatic logic [MAX_WIDTH-1:0] shift_in(input logic [MAX_WIDTH-1:0] w,
                                                     input logic b,
                                                     input logic lsb_first,
                                                     input int unsigned width);
    logic [MAX_WIDTH-1:0] r;
    if (lsb_first) begin
      r = (w >> 1) | (MAX_WIDTH'(b) << (width - 1));
    end else begin
      r = ((w << 1) | MAX_WIDTH'(b)) & ~({MAX_WIDTH{1'b1}} << width);
    end
    return r;
  endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// Serial-in shift register with a saturating bit counter.
module deser_shift_reg
  import deserializador_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic                       clk_100KHz,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       load,
  input  logic                       clear,
  output logic                       full,
  output logic [$clog2(WIDTH+1)-1:0] count,
  output logic [WIDTH-1:0]           word
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;

  // Clear wins over load so a completed word leaves an empty shifter behind.
  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load && (cnt != CW'(WIDTH))) begin
      sr  <= WIDTH'(shift_in(MAX_WIDTH'(sr), data_in, LSB_FIRST, WIDTH));
      cnt <= cnt + CW'(1);
    end
  end

  assign full  = (cnt == CW'(WIDTH));
  assign count = cnt;
  assign word  = sr;

endmodule

// File: rtl/deserializador_buf.sv
// Serial-to-parallel converter with a one-word output buffer and four-phase handshake.
module deserializador_buf
  import deserializador_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic                       clk_100KHz,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       ack_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_ready,
  output logic                       status_out,
  output logic                       overrun_out,
  output logic [$clog2(WIDTH+1)-1:0] count_out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  shift_state_t     shift_state;
  out_state_t       out_state;
  logic             sh_full;
  logic [CW-1:0]    sh_count;
  logic [WIDTH-1:0] sh_word;

  logic             load_c;
  logic             last_bit_c;
  logic             done_idle_c;
  logic             drain_c;
  logic             clear_c;
  logic [WIDTH-1:0] word_next_c;
  logic [WIDTH-1:0] xfer_word_c;

  assign load_c      = (shift_state == S_FILL) && write_in && !sh_full;
  assign last_bit_c  = load_c && (sh_count == CW'(WIDTH - 1));
  assign done_idle_c = last_bit_c && (out_state == O_IDLE);
  assign drain_c     = (shift_state == S_FULL) && (out_state == O_IDLE);
  assign clear_c     = done_idle_c || drain_c;
  assign word_next_c = WIDTH'(shift_in(MAX_WIDTH'(sh_word), data_in, LSB_FIRST, WIDTH));
  // A completing bit bypasses the shifter so data_ready rises the cycle after it.
  assign xfer_word_c = drain_c ? sh_word : word_next_c;

  deser_shift_reg #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_shift (
    .clk_100KHz(clk_100KHz),
    .reset     (reset),
    .data_in   (data_in),
    .load      (load_c),
    .clear     (clear_c),
    .full      (sh_full),
    .count     (sh_count),
    .word      (sh_word)
  );

  assign count_out = sh_count;

  // Shifter and output FSMs with registered outputs.
  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      shift_state <= S_FILL;
      out_state   <= O_IDLE;
      data_out    <= '0;
      data_ready  <= 1'b0;
      status_out  <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      overrun_out <= 1'b0;

      case (shift_state)
        S_FILL: begin
          if (last_bit_c && (out_state != O_IDLE)) begin
            shift_state <= S_FULL;
            status_out  <= 1'b1;
          end
        end
        S_FULL: begin
          overrun_out <= write_in;
          if (out_state == O_IDLE) begin
            shift_state <= S_FILL;
            status_out  <= 1'b0;
          end
        end
        default: shift_state <= S_FILL;
      endcase

      case (out_state)
        O_IDLE: begin
          if (done_idle_c || drain_c) begin
            data_out   <= xfer_word_c;
            data_ready <= 1'b1;
            out_state  <= O_VALID;
          end
        end
        O_VALID: begin
          if (ack_in) out_state <= O_ACK;
        end
        O_ACK: begin
          if (!ack_in) begin
            data_out   <= '0;
            data_ready <= 1'b0;
            out_state  <= O_IDLE;
          end
        end
        default: out_state <= O_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deserializador_buf.sv
// Randomized and directed bench for deserializador_buf against a word-level reference model.
module tb_deserializador_buf;

  logic clk_100KHz = 1'b0;
  logic reset;
  logic data_in;
  logic write_in;
  logic ack_in;

  logic [7:0]  d0_out, d1_out;
  logic [11:0] d2_out;
  logic [3:0]  c0, c1, c2;
  logic        r0, r1, r2, s0, s1, s2, o0, o1, o2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_100KHz = ~clk_100KHz;

  deserializador_buf #(.WIDTH(8), .LSB_FIRST(1'b0)) u0 (
    .clk_100KHz(clk_100KHz), .reset(reset), .data_in(data_in), .write_in(write_in),
    .ack_in(ack_in), .data_out(d0_out), .data_ready(r0), .status_out(s0),
    .overrun_out(o0), .count_out(c0));

  deserializador_buf #(.WIDTH(8), .LSB_FIRST(1'b1)) u1 (
    .clk_100KHz(clk_100KHz), .reset(reset), .data_in(data_in), .write_in(write_in),
    .ack_in(ack_in), .data_out(d1_out), .data_ready(r1), .status_out(s1),
    .overrun_out(o1), .count_out(c1));

  deserializador_buf #(.WIDTH(12), .LSB_FIRST(1'b0)) u2 (
    .clk_100KHz(clk_100KHz), .reset(reset), .data_in(data_in), .write_in(write_in),
    .ack_in(ack_in), .data_out(d2_out), .data_ready(r2), .status_out(s2),
    .overrun_out(o2), .count_out(c2));

  // Reference model: one entry per instance, tracking received bits and the held word.
  int          m_w[3]   = '{8, 8, 12};
  bit          m_lsb[3] = '{1'b0, 1'b1, 1'b0};
  bit          m_bits[3][32];
  int          m_n[3];
  bit          m_full[3];
  bit          m_ready[3];
  bit          m_acked[3];
  bit          m_ovr[3];
  logic [31:0] m_dout[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] assemble(input int i);
    logic [31:0] r = '0;
    for (int k = 0; k < m_w[i]; k++) begin
      if (m_lsb[i]) r = r | (32'(m_bits[i][k]) << k);
      else          r = r | (32'(m_bits[i][k]) << (m_w[i] - 1 - k));
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_n[i] = 0; m_full[i] = 0; m_ready[i] = 0; m_acked[i] = 0;
      m_ovr[i] = 0; m_dout[i] = '0;
    end
  endtask

  task automatic model_step(input bit w, input bit d, input bit a);
    for (int i = 0; i < 3; i++) begin
      bit idle = !m_ready[i];
      if (m_ready[i]) begin
        if (!m_acked[i]) begin
          if (a) m_acked[i] = 1;
        end else if (!a) begin
          m_ready[i] = 0; m_dout[i] = '0; m_acked[i] = 0;
        end
      end
      m_ovr[i] = 0;
      if (!m_full[i]) begin
        if (w) begin
          m_bits[i][m_n[i]] = d;
          m_n[i]++;
          if (m_n[i] == m_w[i]) begin
            if (idle) begin
              m_dout[i] = assemble(i); m_ready[i] = 1; m_acked[i] = 0; m_n[i] = 0;
            end else begin
              m_full[i] = 1;
            end
          end
        end
      end else begin
        if (w) m_ovr[i] = 1;
        if (idle) begin
          m_dout[i] = assemble(i); m_ready[i] = 1; m_acked[i] = 0;
          m_n[i] = 0; m_full[i] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] a_d[3], a_c[3];
    logic        a_r[3], a_s[3], a_o[3];
    a_d = '{32'(d0_out), 32'(d1_out), 32'(d2_out)};
    a_c = '{32'(c0), 32'(c1), 32'(c2)};
    a_r = '{r0, r1, r2};
    a_s = '{s0, s1, s2};
    a_o = '{o0, o1, o2};
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.data_out", i),    a_d[i], m_dout[i]);
      check($sformatf("u%0d.data_ready", i),  32'(a_r[i]), 32'(m_ready[i]));
      check($sformatf("u%0d.status_out", i),  32'(a_s[i]), 32'(m_full[i]));
      check($sformatf("u%0d.overrun_out", i), 32'(a_o[i]), 32'(m_ovr[i]));
      check($sformatf("u%0d.count_out", i),   a_c[i], m_full[i] ? 32'(m_w[i]) : 32'(m_n[i]));
    end
  endtask

  task automatic cycle(input bit w, input bit d, input bit a);
    write_in = w; data_in = d; ack_in = a;
    @(posedge clk_100KHz);
    model_step(w, d, a);
    @(negedge clk_100KHz);
    check_all();
  endtask

  // Assert reset between edges, check the asynchronous clear, release on a later negedge.
  task automatic pulse_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk_100KHz);
    @(negedge clk_100KHz);
    reset = 1'b0;
    check_all();
  endtask

  task automatic send(input logic [31:0] v, input int nbits, input int gap, input bit a);
    logic [31:0] val = v;
    for (int k = nbits - 1; k >= 0; k--) begin
      cycle(1'b1, val[k], a);
      for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, a);
    end
  endtask

  task automatic handshake();
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit ack_lvl;
    logic [31:0] v81;
    reset = 1'b1; data_in = 1'b0; write_in = 1'b0; ack_in = 1'b0;
    model_reset();
    @(negedge clk_100KHz);
    #1;
    check_all();
    @(negedge clk_100KHz);
    reset = 1'b0;

    // First word, both bit orders.
    send(32'hC0, 8, 0, 1'b0);
    check("u0.first_word", 32'(d0_out), 32'hC0);
    check("u1.first_word", 32'(d1_out), 32'h03);
    check("u0.first_ready", 32'(r0), 32'd1);

    // Four-phase release: ready holds through ack high, clears after ack falls.
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1);
    check("u0.ready_during_ack", 32'(r0), 32'd1);
    cycle(1'b0, 1'b0, 1'b0);
    check("u0.ready_after_release", 32'(r0), 32'd0);
    check("u0.data_after_release", 32'(d0_out), 32'h00);

    // Occupied output: second word parks in the shifter, extra bits overrun.
    pulse_reset();
    send(32'hA5, 8, 0, 1'b0);
    send(32'h3C, 8, 0, 1'b0);
    check("u0.status_full", 32'(s0), 32'd1);
    check("u0.count_full", 32'(c0), 32'd8);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0);
    handshake();
    check("u0.parked_still_full", 32'(s0), 32'd1);
    cycle(1'b0, 1'b0, 1'b0);
    check("u0.parked_word", 32'(d0_out), 32'h3C);
    check("u0.status_drained", 32'(s0), 32'd0);
    handshake();

    // Reset mid-word discards the partial word.
    send(32'h1F, 5, 0, 1'b0);
    pulse_reset();
    send(32'h5A, 8, 0, 1'b0);
    check("u0.after_reset_word", 32'(d0_out), 32'h5A);
    handshake();
    handshake();

    // Gapped bits with ack pulsed while idle.
    v81 = 32'h81;
    for (int k = 7; k >= 0; k--) begin
      cycle(1'b1, v81[k], 1'b0);
      if (k != 0) begin
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
      end
    end
    check("u0.gapped_word", 32'(d0_out), 32'h81);
    handshake();

    // Twelve-bit instance.
    pulse_reset();
    send(32'hABC, 12, 0, 1'b0);
    check("u2.word12", 32'(d2_out), 32'hABC);
    check("u2.count_after_word", 32'(c2), 32'd0);
    send(32'h123, 12, 0, 1'b0);
    check("u2.count_occupied", 32'(c2), 32'd12);
    handshake();
    cycle(1'b0, 1'b0, 1'b0);
    check("u2.second_word12", 32'(d2_out), 32'h123);

    // Random traffic with occasional reset.
    ack_lvl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) pulse_reset();
      if ($urandom_range(0, 3) == 0) ack_lvl = ~ack_lvl;
      cycle(($urandom_range(0, 9) < 6), 1'($urandom), ack_lvl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
